// File: rtl/bcd_uart_sched.sv
// Round-robin scheduler sharing one binary-to-BCD converter between NCH channels,
// formatting each result as a 7-byte ASCII frame and streaming it to a UART.
module bcd_uart_sched #(
  parameter int NCH     = 4,
  parameter int TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [NCH-1:0]    ch_req,
  input  logic [12*NCH-1:0] ch_data,
  output logic [NCH-1:0]    ch_ack,
  output logic              conv_start,
  output logic [11:0]       conv_bin,
  input  logic [15:0]       conv_bcd,
  input  logic              conv_valid,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy
);
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, START, CONV, SEND, WAIT} state_t;
  state_t state, state_n;

  logic [PW-1:0] ptr, id, gnt_id;
  logic          gnt_vld;
  logic [TW-1:0] timer;
  logic [2:0]    k;
  logic          err;
  logic [15:0]   bcd;
  logic [7:0]    byte_k;
  logic          do_grant, do_cap, do_tmo, do_send, do_next;

  // Walk from the highest offset down so the closest channel after ptr wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int j = NCH; j >= 1; j--) begin
      idx = PW'((int'(ptr) + j) % NCH);
      if (ch_req[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  function automatic logic [7:0] dchar(input logic [3:0] d, input logic e);
    if (e) return 8'h45;
    if (d > 4'd9) return 8'h3F;
    return {4'h3, d};
  endfunction

  always_comb begin
    case (k)
      3'd0:    byte_k = {4'h3, 4'(id)};
      3'd1:    byte_k = 8'h3A;
      3'd2:    byte_k = dchar(bcd[15:12], err);
      3'd3:    byte_k = dchar(bcd[11:8], err);
      3'd4:    byte_k = dchar(bcd[7:4], err);
      3'd5:    byte_k = dchar(bcd[3:0], err);
      3'd6:    byte_k = 8'h0A;
      default: byte_k = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    do_grant = 1'b0;
    do_cap   = 1'b0;
    do_tmo   = 1'b0;
    do_send  = 1'b0;
    do_next  = 1'b0;
    case (state)
      IDLE:  if (gnt_vld) begin do_grant = 1'b1; state_n = START; end
      START: state_n = CONV;
      CONV: begin
        if (conv_valid) begin
          do_cap  = 1'b1;
          state_n = SEND;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          do_tmo  = 1'b1;
          state_n = SEND;
        end
      end
      SEND: if (!tx_busy) begin do_send = 1'b1; state_n = WAIT; end
      // tx_start is high exactly during the first WAIT cycle, when tx_busy is not yet valid.
      WAIT: if (!tx_start && !tx_busy) begin
        do_next = 1'b1;
        state_n = (k == 3'd6) ? IDLE : SEND;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ptr        <= PW'(NCH - 1);
      id         <= '0;
      ch_ack     <= '0;
      conv_start <= 1'b0;
      conv_bin   <= '0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      timer      <= '0;
      k          <= '0;
      err        <= 1'b0;
      bcd        <= '0;
    end else begin
      ch_ack     <= '0;
      conv_start <= 1'b0;
      tx_start   <= 1'b0;
      if (do_grant) begin
        ch_ack[gnt_id] <= 1'b1;
        conv_bin       <= ch_data[int'(gnt_id)*12 +: 12];
        id             <= gnt_id;
        ptr            <= gnt_id;
      end
      if (state == START) begin
        conv_start <= 1'b1;
        timer      <= '0;
      end
      if (state == CONV) timer <= timer + 1'b1;
      if (do_cap) begin
        bcd <= conv_bcd;
        k   <= '0;
      end
      if (do_tmo) begin
        err <= 1'b1;
        k   <= '0;
      end
      if (do_send) begin
        tx_start <= 1'b1;
        tx_data  <= byte_k;
      end
      if (do_next) begin
        if (k == 3'd6) err <= 1'b0;
        else           k   <= k + 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);
endmodule

// File: tb/tb_bcd_uart_sched.sv
// Directed bench for bcd_uart_sched with behavioural converter and UART models.
module tb_bcd_uart_sched;
  logic        clk = 1'b0, nrst = 1'b0;
  logic [3:0]  ch_req = '0;
  logic [47:0] ch_data = '0;
  logic [3:0]  ch_ack;
  logic        conv_start, conv_valid, conv_valid_m, tx_start, tx_busy, busy;
  logic [11:0] conv_bin;
  logic [15:0] conv_bcd;
  logic [7:0]  tx_data;
  logic        stray = 1'b0, pre_busy = 1'b0;

  int errors = 0, checks = 0;
  int cmode = 0, busy_len = 1, bcnt = 0, ccnt = 0, cyc = 0;
  int nstrobe = 0, bad_strobe = 0, multi_ack = 0, cs_cnt = 0, cs_cyc = 0;
  int base, abase, nb, csb, gap;
  logic [7:0] bytes[$];
  int         tx_cyc[$];
  logic [3:0] acks[$];

  always #5 clk = ~clk;

  assign conv_valid = conv_valid_m | stray;
  assign tx_busy    = (bcnt > 0) | pre_busy;

  bcd_uart_sched #(.NCH(4), .TIMEOUT(32)) dut (
    .clk(clk), .nrst(nrst), .ch_req(ch_req), .ch_data(ch_data), .ch_ack(ch_ack),
    .conv_start(conv_start), .conv_bin(conv_bin), .conv_bcd(conv_bcd),
    .conv_valid(conv_valid), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .busy(busy)
  );

  function automatic logic [15:0] to_bcd(input logic [11:0] v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Converter: 13 cycles after conv_start; cmode 1 = never answers, 2 = inject A123.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ccnt <= 0; conv_valid_m <= 1'b0; conv_bcd <= '0;
    end else begin
      conv_valid_m <= 1'b0;
      if (conv_start) ccnt <= 13;
      else if (ccnt > 0) begin
        ccnt <= ccnt - 1;
        if (ccnt == 1 && cmode != 1) begin
          conv_valid_m <= 1'b1;
          conv_bcd     <= (cmode == 2) ? 16'hA123 : to_bcd(conv_bin);
        end
      end
    end
  end

  // UART: busy for busy_len cycles starting the cycle after tx_start.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) bcnt <= 0;
    else if (tx_start) bcnt <= busy_len;
    else if (bcnt > 0) bcnt <= bcnt - 1;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_start) begin
      bytes.push_back(tx_data);
      tx_cyc.push_back(cyc);
      nstrobe <= nstrobe + 1;
      if (tx_busy) bad_strobe <= bad_strobe + 1;
    end
    if (|ch_ack) begin
      acks.push_back(ch_ack);
      if (!$onehot(ch_ack)) multi_ack <= multi_ack + 1;
    end
    if (conv_start) begin
      cs_cnt <= cs_cnt + 1;
      cs_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [55:0] frame_at(input int b);
    logic [55:0] f = '0;
    for (int i = 0; i < 7; i++) f = {f[47:0], (b + i < bytes.size()) ? bytes[b + i] : 8'h00};
    return f;
  endfunction

  task automatic do_reset();
    nrst = 1'b0; ch_req = '0; stray = 1'b0; pre_busy = 1'b0; cmode = 0; busy_len = 1;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_ack();
    int c = 0;
    while (ch_ack == '0 && c < 100) begin @(negedge clk); c++; end
    chk("ack_seen", |ch_ack, 1);
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int c = 0;
    while (bytes.size() < n && c < budget) begin @(negedge clk); c++; end
    chk("bytes_timeout", bytes.size() >= n, 1);
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy && c < 500) begin @(negedge clk); c++; end
    chk("busy_fall", busy, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ack"}, ch_ack, 0);
    chk({tag, "_cs"}, conv_start, 0);
    chk({tag, "_bin"}, conv_bin, 0);
    chk({tag, "_txd"}, tx_data, 0);
    chk({tag, "_txs"}, tx_start, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    // Reset state
    ch_req = 4'hF; ch_data = {12'd300, 12'd200, 12'd100, 12'd5};
    repeat (3) @(negedge clk);
    chk_zero("rst");
    do_reset();

    // 1: single channel, full-scale sample
    base = bytes.size();
    ch_data[11:0] = 12'd4095; ch_req = 4'b0001;
    wait_ack();
    chk("t1_ack", ch_ack, 4'b0001);
    chk("t1_bin", conv_bin, 12'd4095);
    ch_req = '0;
    @(negedge clk);
    chk("t1_cs_lat", conv_start, 1);
    wait_bytes(base + 7, 400);
    chk("t1_frame", frame_at(base), 56'h303A343039350A);
    wait_idle();

    // 2: all channels held, round-robin order from channel 0
    do_reset();
    base = bytes.size(); abase = acks.size();
    ch_data = {12'd300, 12'd200, 12'd100, 12'd0}; ch_req = 4'hF;
    wait_bytes(base + 35, 2000);
    ch_req = '0;
    chk("t2_order", {acks[abase], acks[abase+1], acks[abase+2], acks[abase+3], acks[abase+4]}, 20'h12481);
    chk("t2_f0", frame_at(base), 56'h303A303030300A);
    chk("t2_f2", frame_at(base + 14), 56'h323A303230300A);
    chk("t2_f3", frame_at(base + 21), 56'h333A303330300A);
    chk("t2_f4", frame_at(base + 28), 56'h303A303030300A);
    wait_idle();

    // 3: converter never answers -> error frame, then err clears
    do_reset();
    base = bytes.size(); csb = cs_cnt;
    cmode = 1; ch_data[23:12] = 12'd7; ch_req = 4'b0010;
    wait_ack();
    chk("t3_ack", ch_ack, 4'b0010);
    ch_req = '0;
    wait_bytes(base + 7, 400);
    chk("t3_frame", frame_at(base), 56'h313A454545450A);
    chk("t3_cs_once", cs_cnt - csb, 1);
    gap = tx_cyc[base] - cs_cyc;
    chk("t3_tmo_gap", (gap >= 32 && gap <= 34), 1);
    wait_idle();
    base = bytes.size();
    cmode = 0; ch_req = 4'b0010;
    wait_ack();
    ch_req = '0;
    wait_bytes(base + 7, 400);
    chk("t3_err_clr", frame_at(base), 56'h313A303030370A);
    wait_idle();

    // 4: slow UART, already busy when SEND is reached
    do_reset();
    base = bytes.size(); nb = nstrobe;
    busy_len = 10; pre_busy = 1'b1; ch_data[11:0] = 12'd123; ch_req = 4'b0001;
    wait_ack();
    ch_req = '0;
    begin
      int c = 0;
      while (!conv_valid && c < 100) begin @(negedge clk); c++; end
      chk("t4_valid_seen", conv_valid, 1);
    end
    repeat (6) @(negedge clk);
    chk("t4_hold", nstrobe - nb, 0);
    pre_busy = 1'b0;
    wait_bytes(base + 7, 1000);
    chk("t4_frame", frame_at(base), 56'h303A303132330A);
    wait_idle();
    chk("t4_strobes", nstrobe - nb, 7);

    // 5: reset during byte 3 aborts the frame
    do_reset();
    base = bytes.size();
    ch_data[11:0] = 12'd555; ch_req = 4'b0001;
    wait_ack();
    ch_req = '0;
    wait_bytes(base + 4, 400);
    nrst = 1'b0;
    @(negedge clk);
    chk_zero("t5_abort");
    nrst = 1'b1;
    nb = nstrobe; abase = acks.size();
    repeat (30) @(negedge clk);
    chk("t5_no_strobe", nstrobe - nb, 0);
    chk("t5_no_ack", acks.size() - abase, 0);
    chk("t5_idle", busy, 0);
    base = bytes.size(); ch_req = 4'b0001;
    wait_ack();
    ch_req = '0;
    wait_bytes(base + 7, 400);
    chk("t5_after", frame_at(base), 56'h303A303535350A);
    wait_idle();

    // 6: stray conv_valid in IDLE, then invalid BCD digit
    do_reset();
    nb = nstrobe; csb = cs_cnt;
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_stray_busy", busy, 0);
    chk("t6_stray_tx", nstrobe - nb, 0);
    chk("t6_stray_cs", cs_cnt - csb, 0);
    base = bytes.size();
    cmode = 2; ch_data[11:0] = 12'd1; ch_req = 4'b0001;
    wait_ack();
    ch_req = '0;
    wait_bytes(base + 7, 400);
    chk("t6_frame", frame_at(base), 56'h303A3F3132330A);
    wait_idle();

    chk("onehot_ack", multi_ack, 0);
    chk("strobe_busy", bad_strobe, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
